bootmem_loader: RTL and testbench

- Parametrised, RAM-backed successor to the fixed boot ROM on the 6502 system bus.
- After reset, an image is streamed in over a byte loader port while the CPU is held in reset; the block then serves CPU reads from a configurable window that includes the reset vector.
- The CPU can permanently unmap the window through a control register; only reset restores it.

---
 rtl/bootmem_loader_pkg.sv | 17 +
 rtl/bootmem_ram.sv | 28 ++
 rtl/bootmem_loader.sv | 137 +++++++++++++
 tb/tb_bootmem_loader.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bootmem_loader_pkg.sv
// rtl/bootmem_loader_pkg.sv - shared types and default placement for the boot memory window
package bootmem_loader_pkg;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        RUN      = 2'd1,
        UNMAPPED = 2'd2
    } bootmem_state_t;

    localparam int BOOTMEM_UNMAP_BIT = 0;

    // Default placement: top page of a 6502 map, control register in I/O space
    localparam int BOOTMEM_BASE = 'hff00;
    localparam int BOOTMEM_SIZE = 256;
    localparam int BOOTMEM_CTRL = 'h4020;

endpackage

// File: rtl/bootmem_ram.sv
// rtl/bootmem_ram.sv - SIZE x DATA_W block RAM, loader write port and registered CPU read port
module bootmem_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on contents or output register so the array maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bootmem_loader.sv
// rtl/bootmem_loader.sv - RAM-backed boot window with byte loader and CPU unmap control
// Optional feature: BOOTMEM_CHECKSUM_EN exposes a load checksum at CTRL_ADDR.
module bootmem_loader
    import bootmem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(BOOTMEM_BASE),
    parameter int                SIZE      = BOOTMEM_SIZE,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(BOOTMEM_CTRL)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              we_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              oe_o,
    output logic              cpu_hold_o,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              loaded_o
);

    localparam int AW = $clog2(SIZE);
    localparam logic [ADDR_W:0] WIN_END = {1'b0, BASE} + (ADDR_W+1)'(SIZE);

    bootmem_state_t    state_q;
    logic [AW-1:0]     wptr_q;
    logic              oe_q;
    logic              cpu_hold_q;
    logic              ld_ready_q;
    logic              loaded_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_src;
    logic              in_win;
    logic              ctrl_rd;
    logic              ld_acc;
    logic              ld_end;
    logic              unmap;
    logic              unused_ok;

    assign in_win = (addr_i >= BASE) && ({1'b0, addr_i} < WIN_END);
    assign ld_acc = (state_q == LOAD) && ld_valid_i && ld_ready_q;
    assign ld_end = ld_last_i || (wptr_q == AW'(SIZE - 1));
    assign unmap  = we_i && (addr_i == CTRL_ADDR) && wdata_i[BOOTMEM_UNMAP_BIT];
    assign unused_ok = ^wdata_i;

    bootmem_ram #(
        .DEPTH (SIZE),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (ld_acc),
        .waddr_i(wptr_q),
        .wdata_i(ld_data_i),
        .raddr_i(addr_i[AW-1:0]),
        .rdata_o(ram_rdata)
    );

`ifdef BOOTMEM_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       sel_sum_q;

    assign ctrl_rd = (addr_i == CTRL_ADDR);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sum_q     <= '0;
            sel_sum_q <= 1'b0;
        end else begin
            if (ld_acc) begin
                sum_q <= sum_q + 8'(ld_data_i);
            end
            sel_sum_q <= ctrl_rd && (state_q != LOAD);
        end
    end

    assign rd_src = sel_sum_q ? DATA_W'(sum_q) : ram_rdata;
`else
    assign ctrl_rd = 1'b0;
    assign rd_src  = ram_rdata;
`endif

    // The RAM output register changes every cycle; hold_q keeps the bus value steady between claims
    assign rdata_o = oe_q ? rd_src : hold_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= LOAD;
            wptr_q     <= '0;
            oe_q       <= 1'b0;
            cpu_hold_q <= 1'b1;
            ld_ready_q <= 1'b0;
            loaded_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            hold_q <= rdata_o;
            oe_q   <= 1'b0;
            case (state_q)
                LOAD: begin
                    ld_ready_q <= 1'b1;
                    if (ld_acc) begin
                        wptr_q <= wptr_q + 1'b1;
                        if (ld_end) begin
                            state_q    <= RUN;
                            ld_ready_q <= 1'b0;
                            cpu_hold_q <= 1'b0;
                            loaded_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    oe_q <= in_win || ctrl_rd;
                    if (unmap) begin
                        state_q <= UNMAPPED;
                    end
                end
                UNMAPPED: begin
                    oe_q <= ctrl_rd;
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign oe_o       = oe_q;
    assign cpu_hold_o = cpu_hold_q;
    assign ld_ready_o = ld_ready_q;
    assign loaded_o   = loaded_q;

endmodule

// File: tb/tb_bootmem_loader.sv
// tb/tb_bootmem_loader.sv - randomized self-checking bench for bootmem_loader against a byte-array model
module tb_bootmem_loader;

    localparam int BASE = 'hff00;
    localparam int SIZE = 256;
    localparam int CTRL = 'h4020;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        oe;
    logic        cpu_hold;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl_mem [SIZE];
    bit         mdl_known [SIZE];
    int         mdl_wptr;
    bit         mdl_loaded;
    bit         mdl_unmapped;
    logic [7:0] mdl_sum;
    logic [7:0] exp_rdata;
    bit         rd_unknown;
    logic [7:0] img [$];

    bootmem_loader dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .we_i      (we),
        .rdata_o   (rdata),
        .oe_o      (oe),
        .cpu_hold_o(cpu_hold),
        .ld_valid_i(ld_valid),
        .ld_data_i (ld_data),
        .ld_last_i (ld_last),
        .ld_ready_o(ld_ready),
        .loaded_o  (loaded)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; addr = '0; wdata = '0; we = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        step();
        step();
        checks++;
        if (oe !== 1'b0 || cpu_hold !== 1'b1 || loaded !== 1'b0 || ld_ready !== 1'b0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: oe=%b cpu_hold=%b loaded=%b ld_ready=%b rdata=%h, want 0 1 0 0 00",
                     oe, cpu_hold, loaded, ld_ready, rdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_first_cycle: ld_ready=%b want 0", ld_ready);
        end
        step();
        checks++;
        if (ld_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: ld_ready=%b cpu_hold=%b want 1 1", ld_ready, cpu_hold);
        end
        mdl_wptr = 0; mdl_loaded = 0; mdl_unmapped = 0; mdl_sum = 8'h00;
        exp_rdata = 8'h00; rd_unknown = 0;
    endtask

    // Streams img[start..]; stops early after abort_after accepts when abort_after >= 0
    task automatic load_image(input bit use_last, input int stall_pct, input int start,
                              input int abort_after, output int n_acc);
        int  i;
        int  budget;
        bit  done;
        i = start; budget = 0; done = 0; n_acc = 0;
        while (!done && i < img.size() && budget < 4000) begin
            ld_valid = ($urandom_range(99) >= stall_pct);
            ld_data  = img[i];
            ld_last  = use_last && (i == img.size() - 1);
            checks++;
            if (ld_ready !== 1'b1 || cpu_hold !== 1'b1 || loaded !== 1'b0 || oe !== 1'b0) begin
                errors++;
                $display("FAIL load_flags: ld_ready=%b cpu_hold=%b loaded=%b oe=%b want 1 1 0 0 (byte %0d)",
                         ld_ready, cpu_hold, loaded, oe, i);
            end
            if (ld_valid) begin
                mdl_mem[mdl_wptr]   = img[i];
                mdl_known[mdl_wptr] = 1;
                mdl_sum  = mdl_sum + img[i];
                done     = ld_last || (mdl_wptr == SIZE - 1);
                mdl_wptr = (mdl_wptr + 1) % SIZE;
                i++;
                n_acc++;
            end
            step();
            budget++;
            if (abort_after >= 0 && n_acc == abort_after) break;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        if (done) begin
            mdl_loaded = 1;
            checks++;
            if (ld_ready !== 1'b0 || cpu_hold !== 1'b0 || loaded !== 1'b1) begin
                errors++;
                $display("FAIL load_done: ld_ready=%b cpu_hold=%b loaded=%b want 0 0 1", ld_ready, cpu_hold, loaded);
            end
        end else if (abort_after < 0) begin
            checks++;
            errors++;
            $display("FAIL load_incomplete: accepted=%0d budget=%0d", n_acc, budget);
        end
    endtask

    task automatic do_read(input int a);
        bit         exp_oe;
        logic [7:0] exp_d;
        bit         known;
        addr = 16'(a); we = 1'b0;
        step();
        exp_oe = 0; exp_d = exp_rdata; known = 1;
        if (mdl_loaded && !mdl_unmapped && a >= BASE && a < BASE + SIZE) begin
            exp_oe = 1; exp_d = mdl_mem[a - BASE]; known = mdl_known[a - BASE];
        end
`ifdef BOOTMEM_CHECKSUM_EN
        else if (mdl_loaded && a == CTRL) begin
            exp_oe = 1; exp_d = mdl_sum;
        end
`endif
        checks++;
        if (oe !== exp_oe) begin
            errors++;
            $display("FAIL read_oe: addr=%h oe=%b want %b", a[15:0], oe, exp_oe);
        end
        if (exp_oe) begin
            if (known) begin
                checks++;
                if (rdata !== exp_d) begin
                    errors++;
                    $display("FAIL read_data: addr=%h rdata=%h want %h", a[15:0], rdata, exp_d);
                end
            end
            exp_rdata = exp_d;
            rd_unknown = !known;
        end else if (!rd_unknown) begin
            checks++;
            if (rdata !== exp_rdata) begin
                errors++;
                $display("FAIL read_hold: addr=%h rdata=%h want %h", a[15:0], rdata, exp_rdata);
            end
        end
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        addr = 16'(a); wdata = d; we = 1'b1;
        if (mdl_loaded && !mdl_unmapped && a == CTRL && d[0]) mdl_unmapped = 1;
        step();
        we = 1'b0;
        rd_unknown = 1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < SIZE; k++) mdl_known[k] = 0;
        do_reset();
    endtask

    task automatic test_full_load();
        int n;
        img.delete();
        for (int k = 0; k < SIZE; k++) img.push_back(8'(k));
        load_image(0, 30, 0, -1, n);
        checks++;
        if (n != SIZE) begin
            errors++;
            $display("FAIL full_count: accepted=%0d want %0d", n, SIZE);
        end
        do_read('hff10);
        for (int k = 0; k < 20; k++) do_read(BASE + $urandom_range(SIZE - 1));
    endtask

    task automatic test_out_of_window();
        int a;
        do_read('hff20);
        do_read('h8000);
        for (int k = 0; k < 10; k++) begin
            a = $urandom_range(BASE - 1);
            if (a == CTRL) a = 'h8000;
            do_read(a);
        end
        do_write('hff00, 8'h77);
        do_read('hff00);
        do_read('hff01);
    endtask

    task automatic test_unmap();
        do_write(CTRL, 8'h00);
        do_read('hfffc);
        do_read('hfffc);
        do_write(CTRL, 8'h01);
        do_read('hfffc);
        do_read('hff10);
        do_write(CTRL, 8'h01);
        do_write(CTRL, 8'h00);
        checks++;
        if (loaded !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_flags: loaded=%b cpu_hold=%b want 1 0", loaded, cpu_hold);
        end
        for (int k = 0; k < 8; k++) do_read(BASE + $urandom_range(SIZE - 1));
        do_read(CTRL);
    endtask

    task automatic test_short_load();
        int n;
        do_reset();
        img.delete();
        img.push_back(8'ha9); img.push_back(8'h55); img.push_back(8'haa); img.push_back(8'h4c);
        load_image(1, 0, 0, -1, n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL short_count: accepted=%0d want 4", n);
        end
        ld_valid = 1'b1; ld_data = 8'hee; ld_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL extra_bytes: ld_ready=%b want 0", ld_ready);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        do_read('hff03);
        do_read('hff04);
        do_read('hff00);
        do_read('hff10);
    endtask

    task automatic test_reset_midload();
        int n;
        do_reset();
        img.delete();
        for (int k = 0; k < 20; k++) img.push_back(8'($urandom));
        load_image(0, 0, 0, 5, n);
        ld_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (ld_ready !== 1'b1 || cpu_hold !== 1'b1) begin
                errors++;
                $display("FAIL stall_flags: ld_ready=%b cpu_hold=%b want 1 1", ld_ready, cpu_hold);
            end
        end
        load_image(0, 25, 5, 6, n);
        do_reset();
        img.delete();
        for (int k = 0; k < 6; k++) img.push_back(8'($urandom));
        load_image(1, 25, 0, -1, n);
        do_read('hff00);
        do_read('hff05);
        do_read('hff08);
        do_read('hff0a);
        do_read('hff20);
    endtask

    task automatic test_checksum();
        int n;
        do_reset();
        img.delete();
        img.push_back(8'h80); img.push_back(8'h90); img.push_back(8'h01);
        load_image(1, 0, 0, -1, n);
        do_read('hff00);
        do_read(CTRL);
        do_reset();
        img.delete();
        for (int k = 0; k < 1 + $urandom_range(40); k++) img.push_back(8'($urandom));
        load_image(1, 20, 0, -1, n);
        do_read(CTRL);
        do_write(CTRL, 8'h01);
        do_read(CTRL);
        do_read('hff00);
    endtask

    task automatic test_reset_midread();
        addr = 16'hff10; we = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (oe !== 1'b0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_read: oe=%b rdata=%h want 0 00", oe, rdata);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_out_of_window();
        test_unmap();
        test_short_load();
        test_reset_midload();
        test_checksum();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
